ctrl_pipe_decoder: RTL and testbench

//  Pipelined successor to the ID-stage control decoder: decodes OpCode/Funct in ID, registers the control bundle into an ID/EX stage register, and holds the internal hazard logic.

---
 rtl/ctrl_pipe_decoder_if.sv | 42 ++++
 rtl/ctrl_pipe_decoder.sv | 149 ++++++++++++++
 tb/tb_ctrl_pipe_decoder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_decoder_if.sv
// ID-stage instruction fields and hazard controls in, EX control bundle and
// pipeline stall/branch indications out of the control decoder.
interface ctrl_pipe_decoder_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic [5:0]         OpCode;
  logic [5:0]         Funct;
  logic [4:0]         RsID;
  logic [4:0]         RtID;
  logic               hold_in;
  logic               flush_in;
  logic               BranchID;
  logic               JumpID;
  logic               JRID;
  logic               stall_out;
  logic               RegWriteEX;
  logic               MemReadEX;
  logic               MemWriteEX;
  logic [1:0]         MemtoRegEX;
  logic [1:0]         RegDstEX;
  logic               ALUSrcEX;
  logic               ExtOpEX;
  logic [ALUOP_W-1:0] ALUOpEX;
  logic [4:0]         RtEX;
  logic               MdStartEX;
  logic [1:0]         MdOpEX;
  logic               md_busy;

  modport master (
    output OpCode, Funct, RsID, RtID, hold_in, flush_in,
    input  BranchID, JumpID, JRID, stall_out,
    input  RegWriteEX, MemReadEX, MemWriteEX, MemtoRegEX, RegDstEX,
    input  ALUSrcEX, ExtOpEX, ALUOpEX, RtEX, MdStartEX, MdOpEX, md_busy
  );

  modport slave (
    input  OpCode, Funct, RsID, RtID, hold_in, flush_in,
    output BranchID, JumpID, JRID, stall_out,
    output RegWriteEX, MemReadEX, MemWriteEX, MemtoRegEX, RegDstEX,
    output ALUSrcEX, ExtOpEX, ALUOpEX, RtEX, MdStartEX, MdOpEX, md_busy
  );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// ID-stage control decoder with ID/EX control register, load-use detection
// and a busy sequencer for the multi-cycle mult/div unit.
module ctrl_pipe_decoder #(
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned MD_LATENCY = 32,
  parameter bit          ENABLE_MD  = 1'b1
) (
  input logic                clk,
  input logic                reset,
  ctrl_pipe_decoder_if.slave bus
);

  localparam int unsigned CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         mem_to_reg;
    logic [1:0]         reg_dst;
    logic               alu_src;
    logic               ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0]         rt;
    logic               md_start;
    logic [1:0]         md_op;
  } ex_bundle_t;

  ex_bundle_t       dec, ex_q;
  logic [0:0]       st_d, st_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0]       alu_class;

  logic [5:0] op, fn;
  logic is_r, is_nop, is_jr, is_jalr, is_j, is_jal, is_branch, is_lw, is_sw;
  logic md_funct, mfhilo_funct, md_cls, mfhilo, md_off;
  logic load_use_stall, md_stall, stall, issue;

  assign op           = bus.OpCode;
  assign fn           = bus.Funct;
  assign is_r         = (op == 6'h00);
  assign is_nop       = is_r && (fn == 6'h00);
  assign is_jr        = is_r && (fn == 6'h08);
  assign is_jalr      = is_r && (fn == 6'h09);
  assign is_j         = (op == 6'h02);
  assign is_jal       = (op == 6'h03);
  assign is_branch    = (op[5:2] == 4'b0001);
  assign is_lw        = (op == 6'h23);
  assign is_sw        = (op == 6'h2b);
  assign md_funct     = is_r && (fn[5:2] == 4'b0110);
  assign mfhilo_funct = is_r && ((fn == 6'h10) || (fn == 6'h12));
  assign md_cls       = ENABLE_MD && md_funct;
  assign mfhilo       = ENABLE_MD && mfhilo_funct;
  // Without the MD unit these encodings behave exactly like the all-zero NOP.
  assign md_off       = !ENABLE_MD && (md_funct || mfhilo_funct);

  assign bus.BranchID = is_branch;
  assign bus.JumpID   = is_j || is_jal || is_jr || is_jalr;
  assign bus.JRID     = is_jr || is_jalr;

  assign load_use_stall = ex_q.mem_read && (ex_q.rt != 5'd0) &&
                          ((ex_q.rt == bus.RsID) || (ex_q.rt == bus.RtID));
  assign md_stall       = (st_q == ST_BUSY) && (md_cls || mfhilo);
  assign stall          = load_use_stall || md_stall;
  assign issue          = md_cls && !bus.flush_in && !stall && !bus.hold_in;
  assign bus.stall_out  = stall;

  always_comb begin
    alu_class = 3'b000;
    case (op)
      6'h00:        alu_class = 3'b010;
      6'h04:        alu_class = 3'b001;
      6'h0c:        alu_class = 3'b100;
      6'h0d:        alu_class = 3'b011;
      6'h0f:        alu_class = 3'b110;
      6'h0a, 6'h0b: alu_class = 3'b101;
      default:      alu_class = 3'b000;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.reg_write = !(is_sw || is_branch || is_j || is_jr || md_cls || is_nop || md_off);
    dec.mem_read  = is_lw;
    dec.mem_write = is_sw;
    if (is_lw)                 dec.mem_to_reg = 2'b01;
    else if (is_jal || is_jalr) dec.mem_to_reg = 2'b10;
    if (is_r)        dec.reg_dst = 2'b01;
    else if (is_jal) dec.reg_dst = 2'b10;
    case (op)
      6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b, 6'h0d: dec.alu_src = 1'b1;
      default:                                                       dec.alu_src = 1'b0;
    endcase
    dec.ext_op      = !((op == 6'h0c) || (op == 6'h0d));
    dec.alu_op[2:0] = alu_class;
    dec.alu_op[3]   = op[0];
    dec.rt          = bus.RtID;
    dec.md_start    = md_cls;
    dec.md_op       = md_cls ? fn[1:0] : 2'b00;
  end

  // md_start in the loaded bundle equals issue: the load branch already excludes hold/flush/stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          ex_q <= '0;
    else if (bus.hold_in)                ex_q <= ex_q;
    else if (bus.flush_in || stall)      ex_q <= '0;
    else                                 ex_q <= dec;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (st_q == ST_IDLE) begin
      if (issue) begin
        st_d  = ST_BUSY;
        cnt_d = CNT_W'(MD_LATENCY - 1);
      end
    end else if (!bus.hold_in) begin
      if (cnt_q == '0) st_d  = ST_IDLE;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.RegWriteEX = ex_q.reg_write;
  assign bus.MemReadEX  = ex_q.mem_read;
  assign bus.MemWriteEX = ex_q.mem_write;
  assign bus.MemtoRegEX = ex_q.mem_to_reg;
  assign bus.RegDstEX   = ex_q.reg_dst;
  assign bus.ALUSrcEX   = ex_q.alu_src;
  assign bus.ExtOpEX    = ex_q.ext_op;
  assign bus.ALUOpEX    = ex_q.alu_op;
  assign bus.RtEX       = ex_q.rt;
  assign bus.MdStartEX  = ex_q.md_start;
  assign bus.MdOpEX     = ex_q.md_op;
  assign bus.md_busy    = (st_q == ST_BUSY);

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: directed hazard/MD scenarios plus random
// instruction streams against a per-instruction truth table and cycle model.
module tb_ctrl_pipe_decoder;
  localparam int unsigned LAT = 4;

  localparam int unsigned I_ADD  = 0;
  localparam int unsigned I_MFHI = 7;
  localparam int unsigned I_MULT = 9;
  localparam int unsigned I_DIV  = 11;
  localparam int unsigned I_JAL  = 14;
  localparam int unsigned I_ORI  = 24;
  localparam int unsigned I_LW   = 26;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_pipe_decoder_if #(.ALUOP_W(4)) bus ();
  ctrl_pipe_decoder #(.ALUOP_W(4), .MD_LATENCY(LAT), .ENABLE_MD(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic rw, mr, mw;
    logic [1:0] m2r, rd;
    logic asrc, eo;
    logic [2:0] cls;
    logic br, jp, jr, md, hl;
  } tab_t;

  typedef struct packed {
    logic rw, mr, mw;
    logic [1:0] m2r, rd;
    logic asrc, eo;
    logic [3:0] alu;
    logic [4:0] rt;
    logic ms;
    logic [1:0] mop;
  } ex_t;

  int errors = 0;
  int checks = 0;

  ex_t  m_ex;
  int   m_rem;
  tab_t c_t;
  logic [5:0] c_fn;
  logic [4:0] c_rt;
  logic c_hd, c_fl, c_stall, c_issue;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-written control truth table, one row per supported instruction.
  function automatic tab_t get_tab(input int unsigned i);
    tab_t t;
    t = '0;
    t.eo = 1'b1;
    if (i <= 12) begin
      t.rd = 2'b01; t.cls = 3'b010; t.rw = 1'b1;
      case (i)
        0:  t.fn = 6'h20;
        1:  t.fn = 6'h22;
        2:  t.fn = 6'h24;
        3:  t.fn = 6'h25;
        4:  t.fn = 6'h2a;
        5:  begin t.fn = 6'h08; t.rw = 1'b0; t.jp = 1'b1; t.jr = 1'b1; end
        6:  begin t.fn = 6'h09; t.m2r = 2'b10; t.jp = 1'b1; t.jr = 1'b1; end
        7:  begin t.fn = 6'h10; t.hl = 1'b1; end
        8:  begin t.fn = 6'h12; t.hl = 1'b1; end
        9:  begin t.fn = 6'h18; t.rw = 1'b0; t.md = 1'b1; end
        10: begin t.fn = 6'h19; t.rw = 1'b0; t.md = 1'b1; end
        11: begin t.fn = 6'h1a; t.rw = 1'b0; t.md = 1'b1; end
        default: begin t.fn = 6'h1b; t.rw = 1'b0; t.md = 1'b1; end
      endcase
    end else begin
      case (i)
        13: begin t.op = 6'h02; t.jp = 1'b1; end
        14: begin t.op = 6'h03; t.jp = 1'b1; t.rw = 1'b1; t.rd = 2'b10; t.m2r = 2'b10; end
        15: begin t.op = 6'h04; t.br = 1'b1; t.cls = 3'b001; end
        16: begin t.op = 6'h05; t.br = 1'b1; end
        17: begin t.op = 6'h06; t.br = 1'b1; end
        18: begin t.op = 6'h07; t.br = 1'b1; end
        19: begin t.op = 6'h08; t.rw = 1'b1; t.asrc = 1'b1; end
        20: begin t.op = 6'h09; t.rw = 1'b1; t.asrc = 1'b1; end
        21: begin t.op = 6'h0a; t.rw = 1'b1; t.asrc = 1'b1; t.cls = 3'b101; end
        22: begin t.op = 6'h0b; t.rw = 1'b1; t.asrc = 1'b1; t.cls = 3'b101; end
        23: begin t.op = 6'h0c; t.rw = 1'b1; t.asrc = 1'b1; t.eo = 1'b0; t.cls = 3'b100; end
        24: begin t.op = 6'h0d; t.rw = 1'b1; t.asrc = 1'b1; t.eo = 1'b0; t.cls = 3'b011; end
        25: begin t.op = 6'h0f; t.rw = 1'b1; t.asrc = 1'b1; t.cls = 3'b110; end
        26: begin t.op = 6'h23; t.rw = 1'b1; t.mr = 1'b1; t.asrc = 1'b1; t.m2r = 2'b01; end
        default: begin t.op = 6'h2b; t.mw = 1'b1; t.asrc = 1'b1; end
      endcase
    end
    return t;
  endfunction

  function automatic ex_t dut_ex();
    return {bus.RegWriteEX, bus.MemReadEX, bus.MemWriteEX, bus.MemtoRegEX, bus.RegDstEX,
            bus.ALUSrcEX, bus.ExtOpEX, bus.ALUOpEX, bus.RtEX, bus.MdStartEX, bus.MdOpEX};
  endfunction

  task automatic drive(input int unsigned idx, input logic [4:0] rs, input logic [4:0] rt,
                       input logic hd, input logic fl);
    logic lu, mds;
    c_t  = get_tab(idx);
    c_fn = (c_t.op == 6'h00) ? c_t.fn : 6'($urandom);
    bus.OpCode = c_t.op; bus.Funct = c_fn; bus.RsID = rs; bus.RtID = rt;
    bus.hold_in = hd; bus.flush_in = fl;
    c_rt = rt; c_hd = hd; c_fl = fl;
    lu      = m_ex.mr && (m_ex.rt != 5'd0) && ((m_ex.rt == rs) || (m_ex.rt == rt));
    mds     = (m_rem > 0) && (c_t.md || c_t.hl);
    c_stall = lu || mds;
    c_issue = c_t.md && !fl && !c_stall && !hd;
    #1;
    check("stall_out", bus.stall_out, c_stall);
    check("BranchID", bus.BranchID, c_t.br);
    check("JumpID", bus.JumpID, c_t.jp);
    check("JRID", bus.JRID, c_t.jr);
    check("md_busy", bus.md_busy, m_rem > 0);
    check("ex_bundle", dut_ex(), m_ex);
  endtask

  task automatic tick();
    ex_t nx;
    @(posedge clk);
    if (!c_hd) begin
      if (c_fl || c_stall) m_ex = '0;
      else begin
        nx.rw = c_t.rw; nx.mr = c_t.mr; nx.mw = c_t.mw; nx.m2r = c_t.m2r; nx.rd = c_t.rd;
        nx.asrc = c_t.asrc; nx.eo = c_t.eo; nx.alu = {c_t.op[0], c_t.cls}; nx.rt = c_rt;
        nx.ms = c_t.md; nx.mop = c_t.md ? c_fn[1:0] : 2'b00;
        m_ex = nx;
      end
      if (m_rem > 0) m_rem--;
      else if (c_issue) m_rem = LAT;
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    bus.OpCode = '0; bus.Funct = '0; bus.RsID = '0; bus.RtID = '0;
    bus.hold_in = 1'b0; bus.flush_in = 1'b0;
    m_ex = '0; m_rem = 0; c_t = '0; c_fn = '0; c_rt = '0;
    c_hd = 1'b0; c_fl = 1'b0; c_stall = 1'b0; c_issue = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex", dut_ex(), 32'd0);
    check("rst_busy", bus.md_busy, 1'b0);
    reset = 1'b1;

    drive(I_ORI, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    check("ori_extop", bus.ExtOpEX, 1'b0);
    check("ori_alusrc", bus.ALUSrcEX, 1'b1);
    check("ori_aluop", bus.ALUOpEX, 4'b1011);
    check("ori_regdst", bus.RegDstEX, 2'b00);

    drive(I_JAL, 5'd0, 5'd0, 1'b0, 1'b0);
    check("jal_jump", bus.JumpID, 1'b1);
    tick();
    check("jal_regdst", bus.RegDstEX, 2'b10);
    check("jal_memtoreg", bus.MemtoRegEX, 2'b10);

    drive(I_LW, 5'd0, 5'd8, 1'b0, 1'b0); tick();
    drive(I_ADD, 5'd8, 5'd9, 1'b0, 1'b0);
    check("lu_stall", bus.stall_out, 1'b1);
    tick();
    drive(I_ADD, 5'd8, 5'd9, 1'b0, 1'b0);
    check("lu_stall_once", bus.stall_out, 1'b0);
    check("lu_bubble", dut_ex(), 32'd0);
    tick();
    check("lu_add_rw", bus.RegWriteEX, 1'b1);
    check("lu_add_rt", bus.RtEX, 5'd9);

    drive(I_LW, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    drive(I_ADD, 5'd0, 5'd0, 1'b0, 1'b0);
    check("lu_zero_nostall", bus.stall_out, 1'b0);
    tick();

    drive(I_MULT, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    check("md_start", bus.MdStartEX, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      drive(I_MFHI, 5'd0, 5'd0, 1'b0, 1'b0);
      if (!bus.stall_out) break;
      n++;
      tick();
      if (k == 0) check("md_start_pulse", bus.MdStartEX, 1'b0);
    end
    check("mfhi_stall_cycles", n, 4);
    tick();
    check("mfhi_ex_rw", bus.RegWriteEX, 1'b1);
    check("mfhi_ex_rd", bus.RegDstEX, 2'b01);

    drive(I_DIV, 5'd3, 5'd4, 1'b0, 1'b1); tick();
    check("flush_md_start", bus.MdStartEX, 1'b0);
    check("flush_busy", bus.md_busy, 1'b0);

    drive(I_MULT, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      drive(I_ADD, 5'd1, 5'd2, (k >= 1 && k <= 3), 1'b0);
      if (!bus.md_busy) break;
      n++;
      tick();
    end
    check("hold_busy_len", n, 7);

    drive(I_MULT, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    drive(I_ADD, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    #2 reset = 1'b0;
    m_ex = '0; m_rem = 0;
    #1;
    check("rst_mid_busy", bus.md_busy, 1'b0);
    check("rst_mid_ex", dut_ex(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rst_rel_busy", bus.md_busy, 1'b0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 27), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
